tcp_stream_hash_client: RTL and testbench

Request-side sequencer for the TCP stream hash engine. Accepts single stream-table operations (lookup, upsert, remove) from the TCP reassembly front end. Converts each into one or two `hash_cmd_intf_t` commands, consumes the matching `hash_ret_intf_t` returns, and delivers one status/result per request downstream. Exactly one engine command is outstanding at any time.

---
 rtl/tcp_stream_hash_client.sv | 263 ++++++++++++++++++++++++++
 tb/tb_tcp_stream_hash_client.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_stream_hash_client.sv
// Purpose: request sequencer for the TCP stream hash engine; one request -> one or two engine commands -> one result.
// Latency: LOOKUP/REMOVE result 3 cycles after the request handshake, UPSERT 5 (cmd_ready high, engine returns 1 cycle after accept).
// Backpressure: one engine command outstanding; cmd held until cmd_ready, result held until resp_ready, req_ready only in IDLE.
//
// Ports: clk/rst_n (async active-low); req_* request in (valid/ready); cmd_* engine command out (valid/ready);
//        ret_valid/ret engine return strobe in; resp_* result out (valid/ready); busy = not IDLE.
// Build option: define HASH_CLIENT_TIMEOUT_EN to add a 16-bit return watchdog (TIMEOUT_CYCLES) that yields status TIMEOUT.

package tcp_stream_hash_pkg;

    typedef logic [95:0]  hashkey_t;
    typedef logic [271:0] hash_data_t;
    typedef logic [15:0]  hash_addr_t;

    // Engine command codes
    localparam logic [2:0] CMD_NOP    = 3'd0;
    localparam logic [2:0] CMD_FIND   = 3'd1;
    localparam logic [2:0] CMD_INSERT = 3'd2;
    localparam logic [2:0] CMD_UPDATE = 3'd3;
    localparam logic [2:0] CMD_DELETE = 3'd4;

    // Engine return codes; 0, 6 and 7 are never produced by a healthy engine
    localparam logic [2:0] RET_FOUND    = 3'd1;
    localparam logic [2:0] RET_ERROR    = 3'd2;
    localparam logic [2:0] RET_INSERTED = 3'd3;
    localparam logic [2:0] RET_DELETED  = 3'd4;
    localparam logic [2:0] RET_SUCCESS  = 3'd5;

    // Request operations
    localparam logic [1:0] OP_LOOKUP = 2'd0;
    localparam logic [1:0] OP_UPSERT = 2'd1;
    localparam logic [1:0] OP_REMOVE = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    // Result status
    localparam logic [2:0] ST_HIT      = 3'd0;
    localparam logic [2:0] ST_MISS     = 3'd1;
    localparam logic [2:0] ST_UPDATED  = 3'd2;
    localparam logic [2:0] ST_INSERTED = 3'd3;
    localparam logic [2:0] ST_REMOVED  = 3'd4;
    localparam logic [2:0] ST_FAIL     = 3'd5;
    localparam logic [2:0] ST_TIMEOUT  = 3'd6;

    typedef struct packed {
        logic [2:0] cmd;
        hashkey_t   hashkey;
        hash_data_t hash_data;
        hash_addr_t hash_node_addr;
    } hash_cmd_intf_t;

    typedef struct packed {
        hash_addr_t hash_node_addr;
        hash_data_t hash_data;
        logic [2:0] hash_ret;
    } hash_ret_intf_t;

endpackage

module tcp_stream_hash_client
    import tcp_stream_hash_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  hashkey_t       req_key,
    input  hash_data_t     req_data,
    output logic           cmd_valid,
    input  logic           cmd_ready,
    output hash_cmd_intf_t cmd,
    input  logic           ret_valid,
    input  hash_ret_intf_t ret,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [2:0]     resp_status,
    output logic [15:0]    resp_addr,
    output hash_data_t     resp_data,
    output logic           busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_CMD2  = 3'd3,
        S_WAIT2 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t     state;
    logic       rst_done;     // keeps req_ready low while reset is applied
    logic [1:0] op_q;
    hashkey_t   key_q;
    hash_data_t data_q;
    logic       upd_path_q;   // second command is an update (1) or an insert (0)
    hash_addr_t ret_addr_q;   // last return seen for the current request
    hash_data_t ret_data_q;

`ifdef HASH_CLIENT_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    assign req_ready = rst_done && (state == S_IDLE);

    // Result of a first-stage return for the single-command operations.
    function automatic logic [2:0] first_status(input logic [1:0] op, input logic [2:0] code);
        logic [2:0] st;
        st = ST_FAIL;
        if (code == RET_ERROR)
            st = ST_MISS;
        else if (op == OP_LOOKUP && code == RET_FOUND)
            st = ST_HIT;
        else if (op == OP_REMOVE && code == RET_DELETED)
            st = ST_REMOVED;
        return st;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rst_done    <= 1'b0;
            op_q        <= 2'd0;
            key_q       <= '0;
            data_q      <= '0;
            upd_path_q  <= 1'b0;
            ret_addr_q  <= '0;
            ret_data_q  <= '0;
            cmd_valid   <= 1'b0;
            cmd         <= '0;
            resp_valid  <= 1'b0;
            resp_status <= 3'd0;
            resp_addr   <= '0;
            resp_data   <= '0;
            busy        <= 1'b0;
`ifdef HASH_CLIENT_TIMEOUT_EN
            wdog        <= '0;
`endif
        end else begin
            rst_done <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q       <= req_op;
                        key_q      <= req_key;
                        data_q     <= req_data;
                        ret_addr_q <= '0;
                        ret_data_q <= '0;
                        busy       <= 1'b1;
                        if (req_op == OP_RSVD) begin
                            resp_valid  <= 1'b1;
                            resp_status <= ST_FAIL;
                            resp_addr   <= '0;
                            resp_data   <= '0;
                            state       <= S_RESP;
                        end else begin
                            cmd_valid          <= 1'b1;
                            cmd.cmd            <= (req_op == OP_REMOVE) ? CMD_DELETE : CMD_FIND;
                            cmd.hashkey        <= req_key;
                            cmd.hash_data      <= req_data;
                            cmd.hash_node_addr <= '0;
                            state              <= S_CMD1;
                        end
                    end
                end

                S_CMD1, S_CMD2: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= (state == S_CMD1) ? S_WAIT1 : S_WAIT2;
`ifdef HASH_CLIENT_TIMEOUT_EN
                        wdog      <= '0;
`endif
                    end
                end

                S_WAIT1: begin
                    if (ret_valid) begin
                        ret_addr_q <= ret.hash_node_addr;
                        ret_data_q <= ret.hash_data;
                        if (op_q == OP_UPSERT &&
                            (ret.hash_ret == RET_FOUND || ret.hash_ret == RET_ERROR)) begin
                            // Existing entry is updated in place; a miss turns into an insert.
                            upd_path_q         <= (ret.hash_ret == RET_FOUND);
                            cmd_valid          <= 1'b1;
                            cmd.cmd            <= (ret.hash_ret == RET_FOUND) ? CMD_UPDATE : CMD_INSERT;
                            cmd.hashkey        <= key_q;
                            cmd.hash_data      <= data_q;
                            cmd.hash_node_addr <= (ret.hash_ret == RET_FOUND) ? ret.hash_node_addr : '0;
                            state              <= S_CMD2;
                        end else begin
                            resp_valid  <= 1'b1;
                            resp_status <= first_status(op_q, ret.hash_ret);
                            resp_addr   <= ret.hash_node_addr;
                            resp_data   <= ret.hash_data;
                            state       <= S_RESP;
                        end
                    end
`ifdef HASH_CLIENT_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        resp_valid  <= 1'b1;
                        resp_status <= ST_TIMEOUT;
                        resp_addr   <= ret_addr_q;
                        resp_data   <= ret_data_q;
                        state       <= S_RESP;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end

                S_WAIT2: begin
                    if (ret_valid) begin
                        ret_addr_q <= ret.hash_node_addr;
                        ret_data_q <= ret.hash_data;
                        resp_valid <= 1'b1;
                        if (upd_path_q)
                            resp_status <= (ret.hash_ret == RET_SUCCESS) ? ST_UPDATED : ST_FAIL;
                        else
                            resp_status <= (ret.hash_ret == RET_INSERTED) ? ST_INSERTED : ST_FAIL;
                        // The engine does not echo data on write; report what was written.
                        resp_addr  <= ret.hash_node_addr;
                        resp_data  <= data_q;
                        state      <= S_RESP;
                    end
`ifdef HASH_CLIENT_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        resp_valid  <= 1'b1;
                        resp_status <= ST_TIMEOUT;
                        resp_addr   <= ret_addr_q;
                        resp_data   <= ret_data_q;
                        state       <= S_RESP;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end

                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    cmd_valid  <= 1'b0;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_stream_hash_client.sv
// Purpose: randomized scoreboard bench for tcp_stream_hash_client with a behavioural reference model.
// Latency: directed cases measure request-to-result cycles; random cases use random engine/consumer delays.
// Backpressure: cmd_ready/resp_ready are withheld randomly; a monitor checks hold stability and pops expectations.

module tb_tcp_stream_hash_client;
    import tcp_stream_hash_pkg::*;

    typedef struct {
        logic [2:0] code;
        hash_addr_t addr;
        hash_data_t data;
    } eng_ret_t;

    typedef struct {
        logic [2:0] status;
        hash_addr_t addr;
        hash_data_t data;
    } exp_resp_t;

    typedef struct {
        logic [1:0] op;
        hashkey_t   key;
        hash_data_t data;
        eng_ret_t   r1;
        eng_ret_t   r2;
        bit         to1;     // engine never answers the first command
        bit         to2;     // engine never answers the second command
        int         crd1;    // cycles cmd_ready is withheld
        int         crd2;
        int         rd1;     // cycles between command accept and return
        int         rd2;
        int         respd;   // cycles resp_ready is withheld
        bit         abort2;  // pulse reset while waiting for the second return
    } req_spec_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = 2'd0;
    hashkey_t       req_key = '0;
    hash_data_t     req_data = '0;
    logic           cmd_valid;
    logic           cmd_ready = 1'b0;
    hash_cmd_intf_t cmd;
    logic           ret_valid = 1'b0;
    hash_ret_intf_t ret = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [2:0]     resp_status;
    logic [15:0]    resp_addr;
    hash_data_t     resp_data;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    hash_cmd_intf_t exp_cmd_q[$];
    exp_resp_t      exp_resp_q[$];

    tcp_stream_hash_client #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_key     (req_key),
        .req_data    (req_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .ret_valid   (ret_valid),
        .ret         (ret),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_addr   (resp_addr),
        .resp_data   (resp_data),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic hash_data_t rnd_data();
        logic [287:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
        return t[271:0];
    endfunction

    function automatic hashkey_t rnd_key();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic eng_ret_t er(input logic [2:0] code, input hash_addr_t addr);
        eng_ret_t r;
        r.code = code;
        r.addr = addr;
        r.data = rnd_data();
        return r;
    endfunction

    // Mostly the expected code, sometimes the miss code, sometimes anything.
    function automatic logic [2:0] rand_code(input logic [2:0] good);
        int x;
        x = $urandom_range(0, 9);
        if (x < 5) return good;
        if (x < 8) return RET_ERROR;
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic req_spec_t mk(input logic [1:0] op);
        req_spec_t s;
        s.op = op; s.key = rnd_key(); s.data = rnd_data();
        s.r1 = er(RET_ERROR, 16'h0); s.r2 = er(RET_ERROR, 16'h0);
        s.to1 = 0; s.to2 = 0;
        s.crd1 = 0; s.crd2 = 0; s.rd1 = 0; s.rd2 = 0; s.respd = 0; s.abort2 = 0;
        return s;
    endfunction

    // Reference model: which commands the engine should see and the single result.
    function automatic void model(input req_spec_t s, output int ncmd,
                                  output hash_cmd_intf_t c1, output hash_cmd_intf_t c2,
                                  output exp_resp_t rsp);
        logic [2:0] code1;
        code1 = s.r1.code;
        c1 = '{cmd: (s.op == OP_REMOVE) ? CMD_DELETE : CMD_FIND, hashkey: s.key,
               hash_data: s.data, hash_node_addr: 16'h0};
        c2 = '0;
        rsp = '{status: ST_FAIL, addr: 16'h0, data: '0};
        ncmd = 0;
        if (s.op == OP_RSVD) return;
        ncmd = 1;
        if (s.to1) begin
            rsp.status = ST_TIMEOUT;
            return;
        end
        rsp.addr = s.r1.addr;
        rsp.data = s.r1.data;
        if (s.op == OP_LOOKUP) begin
            if (code1 == RET_FOUND) rsp.status = ST_HIT;
            else if (code1 == RET_ERROR) rsp.status = ST_MISS;
        end else if (s.op == OP_REMOVE) begin
            if (code1 == RET_DELETED) rsp.status = ST_REMOVED;
            else if (code1 == RET_ERROR) rsp.status = ST_MISS;
        end else if (code1 == RET_FOUND || code1 == RET_ERROR) begin
            ncmd = 2;
            c2 = '{cmd: (code1 == RET_FOUND) ? CMD_UPDATE : CMD_INSERT, hashkey: s.key,
                   hash_data: s.data, hash_node_addr: (code1 == RET_FOUND) ? s.r1.addr : 16'h0};
            if (s.to2) begin
                rsp.status = ST_TIMEOUT;
            end else begin
                rsp.addr = s.r2.addr;
                rsp.data = s.data;
                if (code1 == RET_FOUND)
                    rsp.status = (s.r2.code == RET_SUCCESS) ? ST_UPDATED : ST_FAIL;
                else
                    rsp.status = (s.r2.code == RET_INSERTED) ? ST_INSERTED : ST_FAIL;
            end
        end
    endfunction

    function automatic bit sig(input int w);
        case (w)
            0:       return req_ready;
            1:       return cmd_valid;
            default: return resp_valid;
        endcase
    endfunction

    task automatic wait_high(input int w, input string name);
        int n;
        n = 0;
        while (!sig(w) && n < 200) begin
            tick();
            n++;
        end
        if (!sig(w)) begin
            checks++;
            errors++;
            $display("FAIL %s: wait expired, got 0 expected 1", name);
        end
    endtask

    task automatic run_req(input req_spec_t s, output int lat);
        int             ncmd;
        int             t0;
        hash_cmd_intf_t c1, c2;
        exp_resp_t      rsp;
        eng_ret_t       r;
        model(s, ncmd, c1, c2, rsp);
        if (ncmd >= 1) exp_cmd_q.push_back(c1);
        if (ncmd == 2) exp_cmd_q.push_back(c2);
        if (!s.abort2) exp_resp_q.push_back(rsp);
        lat = -1;

        wait_high(0, "req_ready_wait");
        t0 = cyc;
        req_valid = 1'b1; req_op = s.op; req_key = s.key; req_data = s.data;
        tick();
        req_valid = 1'b0; req_key = rnd_key(); req_data = rnd_data();

        for (int i = 0; i < ncmd; i++) begin
            wait_high(1, "cmd_valid_wait");
            repeat ((i == 0) ? s.crd1 : s.crd2) tick();
            cmd_ready = 1'b1;
            tick();
            cmd_ready = 1'b0;
            if (i == 1 && s.abort2) begin
                check("busy_in_wait2", busy, 1'b1);
                #2 rst_n = 1'b0;
                #1;
                check("abort_cmd_valid", cmd_valid, 1'b0);
                check("abort_resp_valid", resp_valid, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_req_ready", req_ready, 1'b0);
                check("abort_cmd", cmd, '0);
                check("abort_resp_fields", {resp_status, resp_addr, resp_data}, '0);
                tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            if ((i == 0 && s.to1) || (i == 1 && s.to2)) break;
            if (i == 0) r = s.r1; else r = s.r2;
            repeat ((i == 0) ? s.rd1 : s.rd2) tick();
            ret_valid = 1'b1;
            ret = '{hash_node_addr: r.addr, hash_data: r.data, hash_ret: r.code};
            tick();
            ret_valid = 1'b0;
        end

        wait_high(2, "resp_valid_wait");
        lat = cyc - t0;
        for (int i = 0; i < s.respd; i++) begin
            // A stray return while the result is held must be ignored.
            if (i == 0) begin
                ret_valid = 1'b1;
                ret = '{hash_node_addr: 16'hdead, hash_data: rnd_data(), hash_ret: RET_FOUND};
            end
            tick();
            ret_valid = 1'b0;
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Monitor: hold stability and in-order scoreboard pops.
    initial begin
        bit             cmd_hold = 0, resp_hold = 0;
        hash_cmd_intf_t prev_cmd = '0;
        logic [290:0]   prev_resp = '0;
        hash_cmd_intf_t ec;
        exp_resp_t      erp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cmd_hold = 0;
                resp_hold = 0;
            end else begin
                if (cmd_valid && cmd_hold) check("cmd_stable", cmd, prev_cmd);
                if (resp_valid && resp_hold)
                    check("resp_stable", {resp_status, resp_addr, resp_data}, prev_resp);
                if (resp_valid) check("no_req_during_resp", req_ready, 1'b0);
                if (cmd_valid && cmd_ready) begin
                    if (exp_cmd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_cmd: got %h expected none", cmd);
                    end else begin
                        ec = exp_cmd_q.pop_front();
                        check("cmd", cmd, ec);
                    end
                end
                if (resp_valid && resp_ready) begin
                    if (exp_resp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp: got status %0d expected none", resp_status);
                    end else begin
                        erp = exp_resp_q.pop_front();
                        check("resp_status", resp_status, erp.status);
                        check("resp_addr", resp_addr, erp.addr);
                        check("resp_data", resp_data, erp.data);
                    end
                end
                cmd_hold  = cmd_valid && !cmd_ready;
                resp_hold = resp_valid && !resp_ready;
                prev_cmd  = cmd;
                prev_resp = {resp_status, resp_addr, resp_data};
            end
        end
    end

    initial begin
        req_spec_t s;
        int        lat;
        logic [1:0] op;

        #12;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_fields", {resp_status, resp_addr, resp_data}, '0);
        check("rst_cmd", cmd, '0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_req_ready", req_ready, 1'b1);

        s = mk(OP_LOOKUP); s.r1 = er(RET_FOUND, 16'h0012);
        run_req(s, lat); check("lat_lookup", lat, 3);
        s = mk(OP_UPSERT); s.r1 = er(RET_FOUND, 16'h0034); s.r2 = er(RET_SUCCESS, 16'h0034);
        run_req(s, lat); check("lat_upsert", lat, 5);
        s = mk(OP_UPSERT); s.r2 = er(RET_INSERTED, 16'h0007);
        run_req(s, lat);
        s = mk(OP_UPSERT); s.r2 = er(RET_ERROR, 16'h0009);
        run_req(s, lat);
        s = mk(OP_UPSERT); s.r1 = er(RET_FOUND, 16'h0044); s.r2 = er(RET_ERROR, 16'h0044);
        run_req(s, lat);
        s = mk(OP_REMOVE); s.r1 = er(RET_DELETED, 16'h0021); s.crd1 = 5; s.respd = 3;
        run_req(s, lat);
        s = mk(OP_REMOVE); run_req(s, lat);
        s = mk(OP_LOOKUP); run_req(s, lat);
        s = mk(OP_LOOKUP); s.r1 = er(3'd7, 16'h0abc); run_req(s, lat);
        s = mk(OP_UPSERT); s.r1 = er(RET_DELETED, 16'h0055); run_req(s, lat);
        s = mk(OP_RSVD); s.respd = 2; run_req(s, lat);

        s = mk(OP_UPSERT); s.r1 = er(RET_FOUND, 16'h0066); s.abort2 = 1;
        run_req(s, lat);
        s = mk(OP_LOOKUP); s.r1 = er(RET_FOUND, 16'h0077);
        run_req(s, lat); check("lat_after_abort", lat, 3);

`ifdef HASH_CLIENT_TIMEOUT_EN
        s = mk(OP_LOOKUP); s.to1 = 1;
        run_req(s, lat); check("lat_timeout", lat, 10);
        s = mk(OP_LOOKUP); s.r1 = er(RET_FOUND, 16'h0012); s.rd1 = 7;
        run_req(s, lat); check("lat_ret_at_expiry", lat, 10);
        s = mk(OP_UPSERT); s.r1 = er(RET_FOUND, 16'h0088); s.to2 = 1;
        run_req(s, lat);
`endif

        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            s = mk(op);
            s.r1 = er(rand_code((op == OP_REMOVE) ? RET_DELETED : RET_FOUND), 16'($urandom()));
            s.r2 = er(rand_code(RET_SUCCESS), 16'($urandom()));
            if ($urandom_range(0, 1) == 1) s.r2.code = rand_code(RET_INSERTED);
            s.crd1 = $urandom_range(0, 3); s.crd2 = $urandom_range(0, 3);
            s.rd1 = $urandom_range(0, 5);  s.rd2 = $urandom_range(0, 5);
            s.respd = $urandom_range(0, 3);
            run_req(s, lat);
        end

        repeat (4) tick();
        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        check("resp_queue_drained", exp_resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
